// File: rtl/pc_gen_pkg.sv
// Shared types and elaboration helpers for the program-counter generator.
// Used by pc_gen and pc_target_calc.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_e;

    localparam int DEFAULT_IALIGN = 4;
    localparam int ALIGN_BITS     = $clog2(DEFAULT_IALIGN);

    function automatic bit ialign_legal(input int ialign);
        return (ialign == 2) || (ialign == 4);
    endfunction

    function automatic int align_bits(input int ialign);
        return $clog2(ialign);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side handshake between the PC generator (master) and the fetch stage (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            pc_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    modport master (output pc_valid, output pc, output pc_next, input fetch_ready);
    modport slave  (input pc_valid, input pc, input pc_next, output fetch_ready);
endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch-target adder with alignment check.
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALIGN_W = ALIGN_BITS
) (
    input  logic            is_relative,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    always_comb begin
        target     = is_relative ? (base + addr) : addr;
        misaligned = |target[ALIGN_W-1:0];
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: fetch handshake, branch/trap redirects,
// debug halt/resume and misaligned-branch fault capture.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = DEFAULT_IALIGN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    pc_gen_if.master        fetch,
    input  logic            branch_enable,
    input  logic            branch_is_relative,
    input  logic [XLEN-1:0] branch_base,
    input  logic [XLEN-1:0] branch_addr,
    input  logic            trap_enable,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            misaligned_fault,
    output logic [XLEN-1:0] fault_addr
);

    localparam int              AW   = align_bits(IALIGN);
    localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);

    generate
        if (!ialign_legal(IALIGN)) begin : g_ialign_check
            $error("pc_gen: IALIGN must be 2 or 4");
        end
    endgenerate

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;

    logic [XLEN-1:0] br_target;
    logic            br_misaligned;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] seq_pc;

    pc_target_calc #(
        .XLEN    (XLEN),
        .ALIGN_W (AW)
    ) u_target (
        .is_relative (branch_is_relative),
        .base        (branch_base),
        .addr        (branch_addr),
        .target      (br_target),
        .misaligned  (br_misaligned)
    );

    // Trap vectors are trusted: just clear the sub-alignment bits.
    assign trap_target = {trap_vector[XLEN-1:AW], {AW{1'b0}}};
    assign seq_pc      = pc_q + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (en) begin
            fault_d = 1'b0;
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (trap_enable) begin
                        pc_d = trap_target;
                        if (halt_req) state_d = HALT;
                    end else if (branch_enable) begin
                        if (br_misaligned) begin
                            fault_d      = 1'b1;
                            fault_addr_d = br_target;
                            state_d      = FAULT;
                        end else begin
                            pc_d = br_target;
                            if (halt_req) state_d = HALT;
                        end
                    end else begin
                        // An address accepted on the halting edge is consumed, so still advance.
                        if (fetch.fetch_ready) pc_d = seq_pc;
                        if (halt_req) state_d = HALT;
                    end
                end
                HALT: begin
                    if (trap_enable) pc_d = trap_target;
                    if (resume_req && !halt_req) state_d = RUN;
                end
                FAULT: begin
                    if (trap_enable) begin
                        pc_d    = trap_target;
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    assign fetch.pc         = pc_q;
    assign fetch.pc_valid   = (state_q == RUN);
    assign fetch.pc_next    = seq_pc;
    assign misaligned_fault = fault_q;
    assign fault_addr       = fault_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: IALIGN=4 and IALIGN=2 instances share stimulus
// and are compared each cycle against a behavioural model, plus pinned literal checks.
module tb_pc_gen;

    localparam int MB = 0, MR = 1, MH = 2, MF = 3;
    localparam bit [4:0] K_PC = 5'd1, K_V = 5'd2, K_F = 5'd4, K_FA = 5'd8, K_PN = 5'd16;

    typedef struct {
        int          mode;
        logic [31:0] pc;
        logic        flt;
        logic [31:0] faddr;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, ready = 1'b0;
    logic        br_en = 1'b0, br_rel = 1'b0, trap_en = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [31:0] br_base = '0, br_addr = '0, trap_vec = '0;
    logic        flt4, flt2;
    logic [31:0] faddr4, faddr2;

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen_if #(.XLEN(32)) f4 ();
    pc_gen_if #(.XLEN(32)) f2 ();
    assign f4.fetch_ready = ready;
    assign f2.fetch_ready = ready;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .fetch(f4),
        .branch_enable(br_en), .branch_is_relative(br_rel),
        .branch_base(br_base), .branch_addr(br_addr),
        .trap_enable(trap_en), .trap_vector(trap_vec),
        .halt_req(halt), .resume_req(resume),
        .misaligned_fault(flt4), .fault_addr(faddr4)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .fetch(f2),
        .branch_enable(br_en), .branch_is_relative(br_rel),
        .branch_base(br_base), .branch_addr(br_addr),
        .trap_enable(trap_en), .trap_vector(trap_vec),
        .halt_req(halt), .resume_req(resume),
        .misaligned_fault(flt2), .fault_addr(faddr2)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    mst_t m [2];

    function automatic mst_t model_step(mst_t s, int ia);
        mst_t        n;
        logic [31:0] tgt, tv;
        n     = s;
        n.flt = 1'b0;
        tgt   = br_rel ? br_base + br_addr : br_addr;
        tv    = trap_vec - (trap_vec % 32'(ia));
        if (s.mode == MB) begin
            n.mode = MR;
        end else if (s.mode == MR) begin
            if (trap_en) begin
                n.pc = tv;
                n.mode = halt ? MH : MR;
            end else if (br_en && (tgt % 32'(ia)) != 0) begin
                n.flt = 1'b1;
                n.faddr = tgt;
                n.mode = MF;
            end else if (br_en) begin
                n.pc = tgt;
                n.mode = halt ? MH : MR;
            end else begin
                if (ready) n.pc = s.pc + 32'(ia);
                n.mode = halt ? MH : MR;
            end
        end else if (s.mode == MH) begin
            if (trap_en) n.pc = tv;
            if (resume && !halt) n.mode = MR;
        end else begin
            if (trap_en) begin
                n.pc = tv;
                n.mode = MR;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) m[k] <= '{MB, 32'h0, 1'b0, 32'h0};
        end else if (en) begin
            m[0] <= model_step(m[0], 4);
            m[1] <= model_step(m[1], 2);
        end
    end

    // ---------------- compare process ----------------
    logic [31:0] a_pc [2], a_pn [2], a_fa [2];
    logic        a_v  [2], a_f  [2];
    assign a_pc[0] = f4.pc;       assign a_pc[1] = f2.pc;
    assign a_pn[0] = f4.pc_next;  assign a_pn[1] = f2.pc_next;
    assign a_v[0]  = f4.pc_valid; assign a_v[1]  = f2.pc_valid;
    assign a_f[0]  = flt4;        assign a_f[1]  = flt2;
    assign a_fa[0] = faddr4;      assign a_fa[1] = faddr2;

    bit [4:0]    lit_msk [2];
    logic [31:0] lit_pc  [2], lit_fa [2], lit_pn [2];
    logic        lit_v   [2], lit_f  [2];
    string       lit_nm  [2];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            string d;
            d = (k == 0) ? "ia4" : "ia2";
            check({d, ".pc"},         a_pc[k], m[k].pc);
            check({d, ".pc_valid"},   32'(a_v[k]), 32'(m[k].mode == MR));
            check({d, ".pc_next"},    a_pn[k], m[k].pc + ((k == 0) ? 32'd4 : 32'd2));
            check({d, ".fault"},      32'(a_f[k]), 32'(m[k].flt));
            check({d, ".fault_addr"}, a_fa[k], m[k].faddr);
            if (lit_msk[k][0]) check({lit_nm[k], ".pc"},         a_pc[k], lit_pc[k]);
            if (lit_msk[k][1]) check({lit_nm[k], ".pc_valid"},   32'(a_v[k]), 32'(lit_v[k]));
            if (lit_msk[k][2]) check({lit_nm[k], ".fault"},      32'(a_f[k]), 32'(lit_f[k]));
            if (lit_msk[k][3]) check({lit_nm[k], ".fault_addr"}, a_fa[k], lit_fa[k]);
            if (lit_msk[k][4]) check({lit_nm[k], ".pc_next"},    a_pn[k], lit_pn[k]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic set_lit(int k, bit [4:0] msk, logic [31:0] pc, logic v, logic f,
                           logic [31:0] fa, logic [31:0] pn, string nm);
        lit_msk[k] = msk; lit_pc[k] = pc; lit_v[k] = v; lit_f[k] = f;
        lit_fa[k] = fa; lit_pn[k] = pn; lit_nm[k] = nm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
        lit_msk[0] = '0;
        lit_msk[1] = '0;
    endtask

    task automatic step_pc(logic [31:0] pc, logic v, string nm);
        tick();
        set_lit(0, K_PC | K_V, pc, v, 1'b0, 32'h0, 32'h0, nm);
        settle();
    endtask

    initial begin
        lit_msk[0] = '0;
        lit_msk[1] = '0;
        en = 1'b1; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state and boot sequence
        set_lit(0, K_PC | K_V | K_F | K_FA, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_state");
        settle();
        step_pc(32'h0, 1'b1, "boot_run0");
        step_pc(32'h4, 1'b1, "seq4");
        step_pc(32'h8, 1'b1, "seq8");

        // backpressure and enable freeze
        ready = 1'b0;
        repeat (3) step_pc(32'h8, 1'b1, "stall_hold");
        ready = 1'b1;
        step_pc(32'hC, 1'b1, "stall_release");
        en = 1'b0;
        repeat (2) step_pc(32'hC, 1'b1, "en_freeze");
        en = 1'b1;

        // branches (fetch stalled, redirect still applies)
        ready = 1'b0; br_en = 1'b1; br_rel = 1'b0; br_addr = 32'h1000;
        step_pc(32'h1000, 1'b1, "abs_branch");
        br_rel = 1'b1; br_base = 32'h1008; br_addr = 32'h100;
        step_pc(32'h1108, 1'b1, "rel_branch_pos");
        br_base = 32'h1108; br_addr = 32'hFFFF_FFF8;
        step_pc(32'h1100, 1'b1, "rel_branch_neg");

        // misaligned branch: faults at IALIGN=4, accepted at IALIGN=2
        br_rel = 1'b0; br_addr = 32'h1002;
        tick();
        set_lit(0, K_PC | K_V | K_F | K_FA, 32'h1100, 1'b0, 1'b1, 32'h1002, 32'h0, "misalign_ia4");
        set_lit(1, K_PC | K_V | K_F, 32'h1002, 1'b1, 1'b0, 32'h0, 32'h0, "misalign_ia2");
        settle();
        br_en = 1'b0;
        tick();
        set_lit(0, K_V | K_F | K_FA, 32'h0, 1'b0, 1'b0, 32'h1002, 32'h0, "fault_pulse_end");
        settle();
        trap_en = 1'b1; trap_vec = 32'h83;
        step_pc(32'h80, 1'b1, "trap_exit_fault");

        // trap beats branch; halt/resume
        ready = 1'b1; trap_vec = 32'h80; br_en = 1'b1; br_addr = 32'h2000;
        step_pc(32'h80, 1'b1, "trap_over_branch");
        trap_en = 1'b0; br_en = 1'b0; ready = 1'b0; halt = 1'b1;
        step_pc(32'h80, 1'b0, "halt_enter");
        halt = 1'b0; br_en = 1'b1; br_addr = 32'h3000; ready = 1'b1;
        step_pc(32'h80, 1'b0, "halt_branch_ignored");
        br_en = 1'b0; halt = 1'b1; resume = 1'b1;
        step_pc(32'h80, 1'b0, "halt_wins");
        halt = 1'b0;
        step_pc(32'h80, 1'b1, "resume");
        resume = 1'b0;
        step_pc(32'h84, 1'b1, "resume_seq");

        // wrap-around
        br_en = 1'b1; br_addr = 32'hFFFF_FFFC;
        tick();
        set_lit(0, K_PC | K_PN, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 32'h0, "wrap_top");
        settle();
        br_en = 1'b0;
        step_pc(32'h0, 1'b1, "wrap_zero");
        br_en = 1'b1; br_addr = 32'h2000;
        step_pc(32'h2000, 1'b1, "pre_rst_branch");
        br_en = 1'b0;
        tick();
        // asynchronous reset mid-cycle at pc 0x2004
        #2 rst = 1'b1;
        set_lit(0, K_PC | K_V | K_FA, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "async_rst");
        settle();
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (rst) rst = 1'b0;
            else rst = ($urandom_range(0, 199) == 0);
            en      = ($urandom_range(0, 9) != 0);
            ready   = ($urandom_range(0, 9) < 7);
            br_en   = ($urandom_range(0, 99) < 15);
            br_rel  = $urandom_range(0, 1);
            br_base = $urandom;
            br_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                br_base[1:0] = 2'b00;
                br_addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) br_addr = 32'hFFFF_FFFC;
            trap_en  = ($urandom_range(0, 99) < 8);
            trap_vec = $urandom;
            halt     = ($urandom_range(0, 99) < 6);
            resume   = ($urandom_range(0, 99) < 25);
            settle();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
